ucsbece154a_muldiv: RTL and testbench

Iterative multiply/divide unit with private HI/LO registers, providing MULT, MULTU, DIV and DIVU for the multicycle MIPS core. It sits beside the ALU in the datapath; the controller launches an operation, holds in a wait state while `busy_o` is high, and reads results through MFHI/MFLO. Operand width is parametrised, and the unit supports signed operation, divide-by-zero flagging, and MTHI/MTLO writes, which the single-cycle ALU lacks.

---
 rtl/ucsbece154a_muldiv.sv | 149 ++++++++++++++
 tb/tb_ucsbece154a_muldiv.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154a_muldiv.sv
// Iterative multiply/divide unit with private HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with a
// sign-correction (FIX) cycle that writes HI/LO before a one-cycle DONE.
module ucsbece154a_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             divzero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state, w_next;

  // r_acc holds {upper product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  logic [CW-1:0]      r_cnt;
  logic               r_isdiv, r_sa, r_sb, r_dz;

  logic               w_ready, w_launch, w_signed, w_bzero, w_last;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_msum, w_dtrial;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

  assign w_ready    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_launch   = w_ready && start_i;
  assign w_signed   = ~op_i[0];
  assign w_bzero    = (b_i == '0);
  assign w_abs_a    = (w_signed && a_i[WIDTH-1]) ? -a_i : a_i;
  assign w_abs_b    = (w_signed && b_i[WIDTH-1]) ? -b_i : b_i;
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_dtrial   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_b};
  assign w_prod_neg = -r_acc;

  assign busy_o     = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
  assign done_o     = (r_state == S_DONE);
  assign divzero_o  = (r_state == S_DONE) && r_dz;
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; a divide by zero skips the iteration phase
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) w_next = op_i[1] ? (w_bzero ? S_FIX : S_DIV) : S_MUL;
        else         w_next = S_IDLE;
      end
      S_MUL:   if (w_last) w_next = S_FIX;
      S_DIV:   if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Sign correction of the unsigned magnitude result; the raw dividend is
  // recovered from its magnitude and sign for the divide-by-zero HI value
  always_comb begin
    w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
    w_fix_lo = r_acc[WIDTH-1:0];
    if (r_dz) begin
      w_fix_hi = r_sa ? -r_a : r_a;
      w_fix_lo = '1;
    end else if (!r_isdiv) begin
      if (r_sa ^ r_sb) {w_fix_hi, w_fix_lo} = w_prod_neg;
    end else begin
      if (r_sa ^ r_sb) w_fix_lo = -r_acc[WIDTH-1:0];
      if (r_sa)        w_fix_hi = -r_acc[2*WIDTH-1:WIDTH];
    end
  end

  // Operand capture, iteration datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_isdiv <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      if (w_ready) begin
        if (mthi_i) r_hi <= wd_i;
        if (mtlo_i) r_lo <= wd_i;
      end
      if (w_launch) begin
        r_a     <= w_abs_a;
        r_b     <= w_abs_b;
        r_sa    <= w_signed & a_i[WIDTH-1];
        r_sb    <= w_signed & b_i[WIDTH-1];
        r_isdiv <= op_i[1];
        r_dz    <= op_i[1] & w_bzero;
        r_cnt   <= '0;
        r_acc   <= op_i[1] ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
      end
      case (r_state)
        S_MUL: begin
          r_acc <= {w_msum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
        S_DIV: begin
          if (w_dtrial[WIDTH]) r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
          else                 r_acc <= {w_dtrial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ucsbece154a_muldiv.sv
// Self-checking bench for ucsbece154a_muldiv (WIDTH=32): directed literal
// cases followed by randomized traffic, all compared every cycle against a
// latency/arithmetic reference model.
module tb_ucsbece154a_muldiv;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0, b = '0, wd = '0;
  logic          mthi = 1'b0, mtlo = 1'b0;
  logic          busy, done, dz;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ucsbece154a_muldiv #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start),
    .op_i      (op),
    .a_i       (a),
    .b_i       (b),
    .mthi_i    (mthi),
    .mtlo_i    (mtlo),
    .wd_i      (wd),
    .busy_o    (busy),
    .done_o    (done),
    .divzero_o (dz),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  // Arithmetic reference: results straight from integer operators
  function automatic void model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl, output bit rdz);
    longint sp;
    logic [63:0] up;
    int sx, sy;
    rdz = 1'b0;
    rh  = '0;
    rl  = '0;
    case (o)
      2'b00: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {rh, rl} = sp;
      end
      2'b01: begin
        up = {32'd0, x} * {32'd0, y};
        {rh, rl} = up;
      end
      2'b10: begin
        if (y == 0) begin
          rh = x; rl = '1; rdz = 1'b1;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          rh = '0; rl = 32'h8000_0000;
        end else begin
          sx = x; sy = y;
          rl = sx / sy;
          rh = sx % sy;
        end
      end
      default: begin
        if (y == 0) begin
          rh = x; rl = '1; rdz = 1'b1;
        end else begin
          rl = x / y;
          rh = x % y;
        end
      end
    endcase
  endfunction

  // Cycle model: a launch makes the unit busy for WIDTH+1 cycles (1 for
  // divide by zero), after which results appear together with a done pulse
  bit           m_busy = 0, m_done = 0, m_dz = 0, p_dz = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int           m_rem = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0; m_rem = 0;
    end else if (m_busy) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_busy = 0; m_done = 1; m_dz = p_dz; m_hi = p_hi; m_lo = p_lo;
      end
    end else begin
      m_done = 0;
      m_dz   = 0;
      if (mthi) m_hi = wd;
      if (mtlo) m_lo = wd;
      if (start) begin
        model_op(op, a, b, p_hi, p_lo, p_dz);
        m_busy = 1;
        m_rem  = p_dz ? 1 : W + 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({busy, done, dz, hi, lo} !== {m_busy, m_done, m_dz, m_hi, m_lo}) begin
        errors++;
        $display("FAIL cycle_model t=%0t got busy=%b done=%b dz=%b hi=%h lo=%h exp busy=%b done=%b dz=%b hi=%h lo=%h",
                 $time, busy, done, dz, hi, lo, m_busy, m_done, m_dz, m_hi, m_lo);
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Launch one op and wait (bounded) for done; cyc counts cycles from the
  // start cycle to the done cycle, nb counts busy cycles. At cycle inj a
  // stray start and MTHI are presented for one cycle.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int inj, output int cyc, output int nb);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    cyc = 0;
    nb  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) nb++;
      if (cyc == inj) begin
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9; mthi = 1'b1; wd = 32'hAAAA_5555;
      end else begin
        start = 1'b0; mthi = 1'b0;
      end
    end while (!done && cyc < 200);
    start = 1'b0;
    mthi  = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nb, ndone;

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, cyc, nb);
    chk("multu_latency", cyc, 32'd34);
    chk("multu_busy_cycles", nb, 32'd33);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, cyc, nb);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFF1);

    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, cyc, nb);
    chk("mult_minmin_hi", hi, 32'h4000_0000);
    chk("mult_minmin_lo", lo, 32'h0000_0000);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, cyc, nb);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    run_op(2'b11, 32'd100, 32'd7, 0, cyc, nb);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc, nb);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0000_0000);
    chk("div_ovf_flag", {31'd0, dz}, 32'd0);

    run_op(2'b11, 32'h0000_1234, 32'd0, 0, cyc, nb);
    chk("divz_latency", cyc, 32'd2);
    chk("divz_flag", {31'd0, dz}, 32'd1);
    chk("divz_hi", hi, 32'h0000_1234);
    chk("divz_lo", lo, 32'hFFFF_FFFF);

    // Stray start + MTHI mid-MUL must not disturb the first op
    run_op(2'b00, 32'h0001_2345, 32'hFFFF_FFFE, 5, cyc, nb);
    chk("busy_ignore_latency", cyc, 32'd34);
    chk("busy_ignore_hi", hi, 32'hFFFF_FFFF);
    chk("busy_ignore_lo", lo, 32'hFFFD_B976);
    mtlo = 1'b1; wd = 32'h5A5A_5A5A;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'h5A5A_5A5A);
    chk("mtlo_hi_kept", hi, 32'hFFFF_FFFF);

    // Reset during cycle 10 of a DIV
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_hi", hi, '0);
    chk("abort_lo", lo, '0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);

    run_op(2'b01, 32'd6, 32'd7, 0, cyc, nb);
    chk("post_reset_lo", lo, 32'd42);
    chk("post_reset_hi", hi, 32'd0);

    // Randomized traffic, checked by the cycle model only
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 99) < 30);
      op    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      mthi  = ($urandom_range(0, 9) == 0);
      mtlo  = ($urandom_range(0, 9) == 0);
      wd    = $urandom;
      reset = ($urandom_range(0, 399) != 0);
    end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; reset = 1'b1;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
